// File: rtl/mem_access_unit.sv
// Memory-stage sequencer in front of the single-port DataMem: loads, stores and block fills.
// Optional MEM_ACCESS_STORE_ACK_EN: stores and fills also return a one-cycle RspValid acknowledge.
module mem_access_unit #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ReqValid,
    output logic         ReqReady,
    input  logic         ReqWrite,
    input  logic         ReqFill,
    input  logic [A-1:0] ReqAddr,
    input  logic [W-1:0] ReqData,
    input  logic [A-1:0] ReqLen,
    output logic         RspValid,
    output logic [W-1:0] RspData,
    output logic         Busy,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddress,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut,
    output logic [1:0]   DbgState
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

    // Handshake: a request transfers on a posedge where ReqValid && ReqReady; the
    // requester holds all Req* fields stable until then. RspValid has no ready.
    state_t         state;
    state_t         state_nxt;
    logic           ready_q;
    logic           wr_q;
    logic [A:0]     remain_q;
    logic           req_accept;
    logic           last_fill;

    logic           mem_we_d;
    logic [A-1:0]   mem_addr_d;
    logic [W-1:0]   mem_data_d;
    logic           rsp_valid_d;
    logic [W-1:0]   rsp_data_d;
    logic           wr_d;
    logic [A:0]     remain_d;

    assign ReqReady   = ready_q && (state == ST_IDLE);
    assign req_accept = ReqValid && ReqReady;
    assign last_fill  = (remain_q == (A+1)'(1));
    assign Busy       = (state != ST_IDLE);
    assign DbgState   = state;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_accept) begin
                    state_nxt = ReqFill ? ST_FILL : ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_IDLE;
            ST_FILL: begin
                if (last_fill) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Computes next values of the registered Mem*/Rsp* outputs, so no Req* input
    // reaches a Mem* output without passing through a flop.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = MemAddress;
        mem_data_d  = MemDataIn;
        rsp_valid_d = 1'b0;
        rsp_data_d  = RspData;
        wr_d        = wr_q;
        remain_d    = remain_q;
        case (state)
            ST_IDLE: begin
                if (req_accept) begin
                    mem_addr_d = ReqAddr;
                    if (ReqFill) begin
                        mem_we_d   = 1'b1;
                        mem_data_d = ReqData;
                        wr_d       = 1'b0;
                        remain_d   = (ReqLen == '0) ? {1'b1, {A{1'b0}}} : {1'b0, ReqLen};
                    end else begin
                        mem_we_d = ReqWrite;
                        wr_d     = ReqWrite;
                        if (ReqWrite) begin
                            mem_data_d = ReqData;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (!wr_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = MemDataOut;
                end
`ifdef MEM_ACCESS_STORE_ACK_EN
                else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = MemDataIn;
                end
`endif
            end
            ST_FILL: begin
                if (last_fill) begin
                    remain_d = '0;
`ifdef MEM_ACCESS_STORE_ACK_EN
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = MemDataIn;
`endif
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = MemAddress + A'(1);
                    remain_d   = remain_q - (A+1)'(1);
                end
            end
            default: begin
                mem_we_d = 1'b0;
            end
        endcase
    end

    // Async clear drops MemWriteEn immediately, aborting any fill or access in flight.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ready_q    <= 1'b0;
            MemWriteEn <= 1'b0;
            MemAddress <= '0;
            MemDataIn  <= '0;
            RspValid   <= 1'b0;
            RspData    <= '0;
            wr_q       <= 1'b0;
            remain_q   <= '0;
        end else begin
            ready_q    <= 1'b1;
            MemWriteEn <= mem_we_d;
            MemAddress <= mem_addr_d;
            MemDataIn  <= mem_data_d;
            RspValid   <= rsp_valid_d;
            RspData    <= rsp_data_d;
            wr_q       <= wr_d;
            remain_q   <= remain_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit with a behavioural DataMem, response and write scoreboards.
module tb_mem_access_unit;

    localparam int W = 8;
    localparam int A = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         ReqValid, ReqReady, ReqWrite, ReqFill;
    logic [A-1:0] ReqAddr, ReqLen;
    logic [W-1:0] ReqData;
    logic         RspValid, Busy, MemWriteEn;
    logic [W-1:0] RspData, MemDataIn, MemDataOut;
    logic [A-1:0] MemAddress;
    logic [1:0]   DbgState;

    mem_access_unit #(.W(W), .A(A)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqFill(ReqFill),
        .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqLen(ReqLen),
        .RspValid(RspValid), .RspData(RspData), .Busy(Busy),
        .MemWriteEn(MemWriteEn), .MemAddress(MemAddress), .MemDataIn(MemDataIn),
        .MemDataOut(MemDataOut), .DbgState(DbgState)
    );

    // clock / reset block
    always #5 Clk = ~Clk;
    int cyc = 0;
    always @(posedge Clk) cyc++;

    // behavioural DataMem: combinational read, write on posedge
    logic [W-1:0] dmem [0:255];
    assign MemDataOut = dmem[MemAddress];
    always @(posedge Clk) if (MemWriteEn) dmem[MemAddress] <= MemDataIn;

    // scoreboard state
    logic [W-1:0]   ref_mem [0:255];
    logic [W-1:0]   exp_q[$];
    int             exp_cyc_q[$];
    logic [A+W-1:0] exp_wr_q[$];
    int             checks = 0;
    int             failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // response monitor
    logic [W-1:0]   mon_data;
    int             mon_cyc;
    always @(negedge Clk) begin
        if (Reset && RspValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                mon_data = exp_q.pop_front();
                mon_cyc  = exp_cyc_q.pop_front();
                check("rsp_data", 32'(RspData), 32'(mon_data));
                check("rsp_cycle", cyc, mon_cyc);
            end
        end
    end

    // write monitor
    logic [A+W-1:0] mon_wr;
    always @(negedge Clk) begin
        if (MemWriteEn) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_write", {16'd0, MemAddress, MemDataIn}, 32'd0);
            end else begin
                mon_wr = exp_wr_q.pop_front();
                check("write_addr", 32'(MemAddress), 32'(mon_wr[A+W-1:W]));
                check("write_data", 32'(MemDataIn), 32'(mon_wr[W-1:0]));
            end
        end
    end

    // driver: present a request, wait for ready, push expectations, complete on the accept edge
    task automatic issue(input bit fill, input bit wr, input logic [A-1:0] addr,
                         input logic [W-1:0] data, input logic [A-1:0] len, input bit track);
        int waited;
        int n;
        logic [A-1:0] a;
        @(negedge Clk);
        ReqValid = 1'b1; ReqFill = fill; ReqWrite = wr;
        ReqAddr = addr; ReqData = data; ReqLen = len;
        waited = 0;
        while (!ReqReady && waited < 400) begin
            @(negedge Clk);
            waited++;
        end
        if (!ReqReady) begin
            check("req_accept_timeout", 32'd0, 32'd1);
            ReqValid = 1'b0;
            return;
        end
        if (track) begin
            if (fill) begin
                n = (len == 0) ? 256 : int'(len);
                for (int i = 0; i < n; i++) begin
                    a = addr + A'(i);
                    exp_wr_q.push_back({a, data});
                    ref_mem[a] = data;
                end
`ifdef MEM_ACCESS_STORE_ACK_EN
                exp_q.push_back(data);
                exp_cyc_q.push_back(cyc + 1 + n);
`endif
            end else if (wr) begin
                exp_wr_q.push_back({addr, data});
                ref_mem[addr] = data;
`ifdef MEM_ACCESS_STORE_ACK_EN
                exp_q.push_back(data);
                exp_cyc_q.push_back(cyc + 2);
`endif
            end else begin
                exp_q.push_back(ref_mem[addr]);
                exp_cyc_q.push_back(cyc + 2);
            end
        end
        @(posedge Clk);
        #1 ReqValid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_ReqReady", 32'(ReqReady), 32'd0);
        check("rst_RspValid", 32'(RspValid), 32'd0);
        check("rst_RspData", 32'(RspData), 32'd0);
        check("rst_MemWriteEn", 32'(MemWriteEn), 32'd0);
        check("rst_MemAddress", 32'(MemAddress), 32'd0);
        check("rst_MemDataIn", 32'(MemDataIn), 32'd0);
        check("rst_Busy", 32'(Busy), 32'd0);
        check("rst_state", 32'(DbgState), 32'd0);
    endtask

    // counts cycles until ReqReady returns, seen on negedges after the accept edge
    task automatic count_not_ready(output int n);
        n = 0;
        @(negedge Clk);
        while (!ReqReady && n < 400) begin
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic randomize_req();
        ReqValid = 1'($urandom_range(0, 1));
        ReqFill  = 1'($urandom_range(0, 1));
        ReqWrite = 1'($urandom_range(0, 1));
        ReqAddr  = 8'($urandom_range(0, 255));
        ReqData  = 8'($urandom_range(0, 255));
        ReqLen   = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int n;
        int k;
        int last_acc;
        int guard;
        ReqValid = 1'b0; ReqFill = 1'b0; ReqWrite = 1'b0;
        ReqAddr = '0; ReqData = '0; ReqLen = '0;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end

        // reset state and release
        repeat (3) @(negedge Clk);
        check_reset_outputs();
        Reset = 1'b1;
        @(negedge Clk);
        check("ready_after_release", 32'(ReqReady), 32'd1);
        check("idle_after_release", 32'(DbgState), 32'd0);

        // store then load same address: 0xA5 back two cycles after accept
        issue(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
        repeat (3) @(negedge Clk);

        // wrapping fill 0xFE..0x00 with neighbours untouched (0xFD->0xA7, 0x01->0x5B)
        issue(1'b1, 1'b0, 8'hFE, 8'h3C, 8'd3, 1'b1);
        count_not_ready(n);
        check("fill3_not_ready_cycles", n, 3);
        issue(1'b0, 1'b0, 8'hFD, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'hFE, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        repeat (3) @(negedge Clk);

        // back-to-back loads with ReqValid held high: accepts every 2 cycles
        @(negedge Clk);
        ReqValid = 1'b1; ReqFill = 1'b0; ReqWrite = 1'b0; ReqAddr = 8'h20;
        k = 0; last_acc = 0; guard = 0;
        while (k < 6 && guard < 100) begin
            if (ReqReady) begin
                check("no_accept_while_busy", 32'(Busy), 32'd0);
                exp_q.push_back(ref_mem[ReqAddr]);
                exp_cyc_q.push_back(cyc + 2);
                if (k > 0) check("accept_spacing", cyc - last_acc, 2);
                last_acc = cyc;
                k++;
                @(posedge Clk);
                #1 ReqAddr = ReqAddr + 8'd1;
            end
            @(negedge Clk);
            guard++;
        end
        ReqValid = 1'b0;
        check("stream_accepts", k, 6);
        repeat (3) @(negedge Clk);

        // reset during fill of 10 after 5 writes: exactly 0x40..0x44 written
        issue(1'b1, 1'b0, 8'h40, 8'h77, 8'd10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_wr_q.push_back({8'h40 + 8'(i), 8'h77});
            ref_mem[8'h40 + 8'(i)] = 8'h77;
        end
        repeat (5) @(posedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("abort_fill_we", 32'(MemWriteEn), 32'd0);
        check("abort_fill_busy", 32'(Busy), 32'd0);
        check("abort_fill_rspvalid", 32'(RspValid), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        issue(1'b0, 1'b0, 8'h44, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h45, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1);
        repeat (3) @(negedge Clk);

        // reset during a load's ACCESS cycle with random inputs: no response
        issue(1'b0, 1'b0, 8'h30, 8'h00, 8'h00, 1'b0);
        #2;
        randomize_req();
        Reset = 1'b0;
        #1 check_reset_outputs();
        repeat (3) begin
            @(negedge Clk);
            randomize_req();
        end
        #1 check_reset_outputs();
        ReqValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("ready_after_midrun_reset", 32'(ReqReady), 32'd1);
        check("idle_after_midrun_reset", 32'(DbgState), 32'd0);

        // full-memory clear with ReqLen=0
        issue(1'b1, 1'b0, 8'h00, 8'h00, 8'd0, 1'b1);
        count_not_ready(n);
        check("fill256_busy_cycles", n, 256);
        issue(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h44, 8'h00, 8'h00, 1'b1);

        // store/load after clear
        issue(1'b0, 1'b1, 8'h80, 8'hC3, 8'h00, 1'b1);
        issue(1'b0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1);
        repeat (4) @(negedge Clk);

        check("rsp_queue_drained", exp_q.size(), 0);
        check("write_queue_drained", exp_wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
